// File: rtl/fm_pkg.sv
// Constants and state encoding shared by the hop sequencer and the FM modulator.
package fm_pkg;

  localparam int unsigned CTRL_W = 32;
  localparam int unsigned DEV_W  = 5;

  typedef enum logic [1:0] {
    StIdle,
    StGuard,
    StDwell
  } hop_state_e;

endpackage

// File: rtl/fm_hop_table.sv
// Hop-table register file: one synchronous write port, one combinational read port.
module fm_hop_table
  import fm_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned IDX_W   = $clog2(DEPTH),
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               we,
  input  logic [IDX_W-1:0]   waddr,
  input  logic [CTRL_W-1:0]  wctr,
  input  logic [DEV_W-1:0]   wdev,
  input  logic [DWELL_W-1:0] wdwell,
  input  logic [IDX_W-1:0]   raddr,
  output logic [CTRL_W-1:0]  rctr,
  output logic [DEV_W-1:0]   rdev,
  output logic [DWELL_W-1:0] rdwell
);

  logic [CTRL_W-1:0]  ctr_mem   [DEPTH];
  logic [DEV_W-1:0]   dev_mem   [DEPTH];
  logic [DWELL_W-1:0] dwell_mem [DEPTH];

  // Full-width address compare: writes at or beyond DEPTH match no entry.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (we && (32'(waddr) == i)) begin
        ctr_mem[i]   <= wctr;
        dev_mem[i]   <= wdev;
        dwell_mem[i] <= wdwell;
      end
    end
  end

  always_comb begin
    rctr   = '0;
    rdev   = '0;
    rdwell = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (32'(raddr) == i) begin
        rctr   = ctr_mem[i];
        rdev   = dev_mem[i];
        rdwell = dwell_mem[i];
      end
    end
  end

endmodule

// File: rtl/fm_hop_sequencer.sv
// Frequency-hopping controller: steps through the hop table, driving the modulator's
// center word and deviation, with a muted guard interval after every hop.
module fm_hop_sequencer
  import fm_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned IDX_W   = $clog2(DEPTH),
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned GUARD   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_addr,
  input  logic [CTRL_W-1:0]  cfg_ctr,
  input  logic [DEV_W-1:0]   cfg_dev,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [IDX_W-1:0]   last_idx,
  input  logic               loop,
  input  logic               start,
  input  logic               stop,
  output logic [CTRL_W-1:0]  ctr_ctrl,
  output logic [DEV_W-1:0]   deviation,
  output logic               mute,
  output logic               hop,
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   cur_idx
);

  localparam int unsigned CNT_W = DWELL_W;
  localparam logic [CNT_W-1:0] GUARD_LOAD = (GUARD > 0) ? CNT_W'(GUARD - 1) : '0;

  hop_state_e         st_q, st_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [IDX_W-1:0]   idx_q, idx_d, last_q, last_d;
  logic               loop_q, loop_d;
  logic [CTRL_W-1:0]  ctr_q, ctr_d;
  logic [DEV_W-1:0]   dev_q, dev_d;
  logic               mute_q, mute_d, hop_q, hop_d, busy_q, busy_d, done_q, done_d;

  logic               load;
  logic [IDX_W-1:0]   rd_idx;
  logic [CTRL_W-1:0]  rd_ctr;
  logic [DEV_W-1:0]   rd_dev;
  logic [DWELL_W-1:0] rd_dwell;
  logic [CNT_W-1:0]   rd_cnt;

  fm_hop_table #(
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .DWELL_W(DWELL_W)
  ) u_table (
    .clk   (clk),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wctr  (cfg_ctr),
    .wdev  (cfg_dev),
    .wdwell(cfg_dwell),
    .raddr (rd_idx),
    .rctr  (rd_ctr),
    .rdev  (rd_dev),
    .rdwell(rd_dwell)
  );

  // Counters hold remaining-cycles-minus-one; a zero dwell behaves as one cycle.
  assign rd_cnt = (rd_dwell == '0) ? '0 : rd_dwell - 1'b1;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    hold_d = hold_q;
    idx_d  = idx_q;
    last_d = last_q;
    loop_d = loop_q;
    ctr_d  = ctr_q;
    dev_d  = dev_q;
    mute_d = mute_q;
    busy_d = busy_q;
    hop_d  = 1'b0;
    done_d = 1'b0;
    load   = 1'b0;
    rd_idx = '0;

    unique case (st_q)
      StIdle: begin
        if (start && !stop) begin
          load   = 1'b1;
          loop_d = loop;
          last_d = (32'(last_idx) > DEPTH - 1) ? IDX_W'(DEPTH - 1) : last_idx;
        end
      end
      StGuard: begin
        if (stop) begin
          st_d   = StIdle;
          busy_d = 1'b0;
          mute_d = 1'b1;
        end else if (cnt_q == '0) begin
          st_d   = StDwell;
          cnt_d  = hold_q;
          mute_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDwell: begin
        // stop is checked first so it wins over a coincident hop or completion.
        if (stop) begin
          st_d   = StIdle;
          busy_d = 1'b0;
          mute_d = 1'b1;
        end else if (cnt_q == '0) begin
          if (idx_q != last_q) begin
            load   = 1'b1;
            rd_idx = idx_q + 1'b1;
          end else if (loop_q) begin
            load = 1'b1;
          end else begin
            st_d   = StIdle;
            busy_d = 1'b0;
            mute_d = 1'b1;
            done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: st_d = StIdle;
    endcase

    if (load) begin
      idx_d  = rd_idx;
      ctr_d  = rd_ctr;
      dev_d  = rd_dev;
      hold_d = rd_cnt;
      hop_d  = 1'b1;
      busy_d = 1'b1;
      if (GUARD > 0) begin
        st_d   = StGuard;
        cnt_d  = GUARD_LOAD;
        mute_d = 1'b1;
      end else begin
        st_d   = StDwell;
        cnt_d  = rd_cnt;
        mute_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= StIdle;
      cnt_q  <= '0;
      hold_q <= '0;
      idx_q  <= '0;
      last_q <= '0;
      loop_q <= 1'b0;
      ctr_q  <= '0;
      dev_q  <= '0;
      mute_q <= 1'b1;
      hop_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
      idx_q  <= idx_d;
      last_q <= last_d;
      loop_q <= loop_d;
      ctr_q  <= ctr_d;
      dev_q  <= dev_d;
      mute_q <= mute_d;
      hop_q  <= hop_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign ctr_ctrl  = ctr_q;
  assign deviation = dev_q;
  assign mute      = mute_q;
  assign hop       = hop_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cur_idx   = idx_q;

endmodule

// File: tb/tb_fm_hop_sequencer.sv
// Directed bench for fm_hop_sequencer (DEPTH=8, 4-bit index so clamping is exercised).
module tb_fm_hop_sequencer;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned DWELL_W = 16;
  localparam int unsigned GUARD   = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cfg_we = 1'b0;
  logic [IDX_W-1:0]   cfg_addr = '0;
  logic [31:0]        cfg_ctr = '0;
  logic [4:0]         cfg_dev = '0;
  logic [DWELL_W-1:0] cfg_dwell = '0;
  logic [IDX_W-1:0]   last_idx = '0;
  logic               loop = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic [31:0]        ctr_ctrl;
  logic [4:0]         deviation;
  logic               mute, hop, busy, done;
  logic [IDX_W-1:0]   cur_idx;

  fm_hop_sequencer #(
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .DWELL_W(DWELL_W),
    .GUARD  (GUARD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_ctr  (cfg_ctr),
    .cfg_dev  (cfg_dev),
    .cfg_dwell(cfg_dwell),
    .last_idx (last_idx),
    .loop     (loop),
    .start    (start),
    .stop     (stop),
    .ctr_ctrl (ctr_ctrl),
    .deviation(deviation),
    .mute     (mute),
    .hop      (hop),
    .busy     (busy),
    .done     (done),
    .cur_idx  (cur_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int          hop_n;
  int          done_t;
  int          hop_t   [16];
  logic [31:0] hop_ctr [16];
  logic [4:0]  hop_dev [16];
  logic [3:0]  hop_idx [16];
  int          mute_low[16];
  bit          found;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [3:0] a, input logic [31:0] c, input logic [4:0] d,
                             input logic [15:0] w);
    cfg_addr  = a;
    cfg_ctr   = c;
    cfg_dev   = d;
    cfg_dwell = w;
    cfg_we    = 1'b1;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Records hop times/values, done time and per-entry unmuted cycles; t=0 is the current sample.
  task automatic trace(input int ncyc);
    hop_n  = 0;
    done_t = -1;
    for (int i = 0; i < 16; i++) mute_low[i] = 0;
    for (int t = 0; t < ncyc; t++) begin
      if (hop && hop_n < 16) begin
        hop_t[hop_n]   = t;
        hop_ctr[hop_n] = ctr_ctrl;
        hop_dev[hop_n] = deviation;
        hop_idx[hop_n] = cur_idx;
        hop_n++;
      end
      if (done) done_t = t;
      if (!mute) mute_low[cur_idx]++;
      tick();
    end
  endtask

  task automatic wait_hop_idx(input logic [3:0] idx, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (hop && cur_idx == idx) ok = 1'b1;
    end
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;

    // Idle after reset
    trace(10);
    check_eq("idle_hops", hop_n, 0);
    check_eq("idle_done", done_t, -1);
    check_eq("idle_mute", mute, 1);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_ctr", ctr_ctrl, 0);
    check_eq("idle_dev", deviation, 0);
    check_eq("idle_idx", cur_idx, 0);

    write_entry(4'd0, 32'h0100_0000, 5'd3, 16'd5);
    write_entry(4'd1, 32'h0200_0000, 5'd4, 16'd2);
    write_entry(4'd2, 32'h0300_0000, 5'd5, 16'd0);
    for (int i = 3; i < 8; i++) write_entry(4'(i), 32'h0400_0000 + 32'(i), 5'(i), 16'd1);
    write_entry(4'd8, 32'hDEAD_BEEF, 5'd31, 16'd7);  // out of range, must be dropped

    // Single pass, three entries
    last_idx = 4'd2;
    loop     = 1'b0;
    pulse_start();
    trace(30);
    check_eq("p1_hop_count", hop_n, 3);
    check_eq("p1_gap01", hop_t[1] - hop_t[0], 9);
    check_eq("p1_gap12", hop_t[2] - hop_t[1], 6);
    check_eq("p1_done_gap", done_t - hop_t[2], 5);
    check_eq("p1_mute_low0", mute_low[0], 5);
    check_eq("p1_mute_low1", mute_low[1], 2);
    check_eq("p1_mute_low2", mute_low[2], 1);
    check_eq("p1_ctr1", hop_ctr[1], 32'h0200_0000);
    check_eq("p1_dev2", hop_dev[2], 5);
    check_eq("p1_end_busy", busy, 0);
    check_eq("p1_end_mute", mute, 1);
    check_eq("p1_hold_ctr", ctr_ctrl, 32'h0300_0000);

    // Looping, then stop on a hop cycle
    loop = 1'b1;
    pulse_start();
    check_eq("lp_first_hop", hop, 1);
    check_eq("lp_first_idx", cur_idx, 0);
    repeat (20) tick();
    check_eq("lp_wrap_idx", cur_idx, 0);
    check_eq("lp_wrap_hop", hop, 1);
    check_eq("lp_wrap_busy", busy, 1);
    check_eq("lp_wrap_ctr", ctr_ctrl, 32'h0100_0000);
    repeat (8) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("stop_hop", hop, 0);
    check_eq("stop_busy", busy, 0);
    check_eq("stop_mute", mute, 1);
    check_eq("stop_idx", cur_idx, 0);
    trace(20);
    check_eq("stop_no_hop", hop_n, 0);
    check_eq("stop_no_done", done_t, -1);

    // last_idx clamp to DEPTH-1
    last_idx = 4'd15;
    loop     = 1'b0;
    pulse_start();
    trace(50);
    check_eq("cl_hop_count", hop_n, 8);
    check_eq("cl_entry0_intact", hop_ctr[0], 32'h0100_0000);
    check_eq("cl_last_idx", hop_idx[7], 7);
    check_eq("cl_last_ctr", hop_ctr[7], 32'h0400_0007);
    check_eq("cl_last_t", hop_t[7], 40);
    check_eq("cl_done_t", done_t, 45);

    // Rewrite an entry while it plays
    loop = 1'b1;
    pulse_start();
    wait_hop_idx(4'd3, 60, found);
    check_eq("rw_found1", found, 1);
    check_eq("rw_old_ctr", ctr_ctrl, 32'h0400_0003);
    write_entry(4'd3, 32'h0AAA_0000, 5'd9, 16'd1);
    check_eq("rw_still_old", ctr_ctrl, 32'h0400_0003);
    wait_hop_idx(4'd3, 100, found);
    check_eq("rw_found2", found, 1);
    check_eq("rw_new_ctr", ctr_ctrl, 32'h0AAA_0000);

    // start while busy is ignored
    pulse_start();
    check_eq("sb_idx", cur_idx, 3);
    check_eq("sb_hop", hop, 0);
    check_eq("sb_busy", busy, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("sb_stopped", busy, 0);

    // start and stop together in idle
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check_eq("ss_busy", busy, 0);
    check_eq("ss_hop", hop, 0);
    check_eq("ss_mute", mute, 1);

    // Reset mid-dwell
    last_idx = 4'd2;
    loop     = 1'b0;
    pulse_start();
    repeat (5) tick();
    check_eq("rst_pre_mute", mute, 0);
    reset = 1'b1;
    tick();
    check_eq("rst_ctr", ctr_ctrl, 0);
    check_eq("rst_dev", deviation, 0);
    check_eq("rst_mute", mute, 1);
    check_eq("rst_hop", hop, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_idx", cur_idx, 0);
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
